// File: rtl/int_router.sv
// int_router: sticky interrupt status routed to NOUT pins, each shaped as a level or
// as a pulse with a cold time, optional repeat and re-trigger.
module int_router #(
    parameter int NSRC = 16,
    parameter int NOUT = 2,
    parameter int WW   = 11,
    parameter int CW   = 6
) (
    input  logic                 clk_32k,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_flag,
    input  logic [NSRC-1:0]      rg_int_enable,
    input  logic [NSRC-1:0]      rg_int_clr,
    input  logic [NSRC*NOUT-1:0] rg_int_route,
    input  logic [NOUT-1:0]      rg_out_low_en,
    input  logic [NOUT-1:0]      rg_out_level_en,
    input  logic [NOUT-1:0]      rg_out_repeat,
    input  logic [NOUT*WW-1:0]   rg_out_width,
    input  logic [NOUT*CW-1:0]   rg_cold_time,
    output logic [NSRC-1:0]      int_status,
    output logic                 int_pend_vld,
    output logic [4:0]           int_pend_id,
    output logic [NOUT-1:0]      int_out
);

    localparam int CNTW = (WW > CW + 5) ? WW : CW + 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_COLD
    } state_t;

    logic [NSRC-1:0] src_d1;
    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] status_nxt;
    logic [NSRC-1:0] pend_mask;
    logic            pend_vld_nxt;
    logic [4:0]      pend_id_nxt;

    logic [NOUT-1:0] on;
    logic [NOUT-1:0] on_d1;
    logic [NOUT-1:0] level_d1;
    logic [NOUT-1:0] act_q;
    logic [NOUT-1:0] act_d;
    logic [NOUT-1:0] retrig_q;
    logic [NOUT-1:0] retrig_d;
    state_t          state_q [NOUT];
    state_t          state_d [NOUT];
    logic [CNTW-1:0] cnt_q   [NOUT];
    logic [CNTW-1:0] cnt_d   [NOUT];

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        evt          = src_flag & ~src_d1;
        status_nxt   = evt | (int_status & ~rg_int_clr);
        pend_mask    = status_nxt & rg_int_enable;
        pend_vld_nxt = |pend_mask;
        pend_id_nxt  = '0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_mask[i]) begin
                pend_id_nxt = 5'(i);
            end
        end
    end

    always_comb begin
        on = '0;
        for (int k = 0; k < NOUT; k++) begin
            on[k] = |(int_status & rg_int_enable & rg_int_route[k*NSRC +: NSRC]);
        end
    end

    always_comb begin
        act_d    = act_q;
        retrig_d = retrig_q;
        for (int k = 0; k < NOUT; k++) begin
            logic [CNTW-1:0] width_k;
            logic [CNTW-1:0] cold_last;
            logic            on_rise;

            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            width_k    = CNTW'(rg_out_width[k*WW +: WW]);
            // (cold+1)*32-1 is simply the cold field with five ones appended.
            cold_last  = CNTW'({rg_cold_time[k*CW +: CW], 5'h1f});
            on_rise    = on[k] & ~on_d1[k];

            if (rg_out_level_en[k] != level_d1[k]) begin
                state_d[k]  = ST_IDLE;
                cnt_d[k]    = '0;
                act_d[k]    = 1'b0;
                retrig_d[k] = 1'b0;
            end else if (rg_out_level_en[k]) begin
                state_d[k]  = ST_IDLE;
                cnt_d[k]    = '0;
                act_d[k]    = on[k];
                retrig_d[k] = 1'b0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        if (on_rise) begin
                            state_d[k] = ST_ACTIVE;
                            cnt_d[k]   = '0;
                            act_d[k]   = 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (cnt_q[k] == width_k) begin
                            state_d[k] = ST_COLD;
                            cnt_d[k]   = '0;
                            act_d[k]   = 1'b0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNTW'(1);
                        end
                    end
                    ST_COLD: begin
                        if (on_rise) begin
                            retrig_d[k] = 1'b1;
                        end
                        if (cnt_q[k] == cold_last) begin
                            cnt_d[k]    = '0;
                            retrig_d[k] = 1'b0;
                            if (on[k] && (rg_out_repeat[k] || retrig_q[k] || on_rise)) begin
                                state_d[k] = ST_ACTIVE;
                                act_d[k]   = 1'b1;
                            end else begin
                                state_d[k] = ST_IDLE;
                            end
                        end else begin
                            cnt_d[k] = cnt_q[k] + CNTW'(1);
                        end
                    end
                    default: begin
                        state_d[k]  = ST_IDLE;
                        cnt_d[k]    = '0;
                        act_d[k]    = 1'b0;
                        retrig_d[k] = 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<='; the per-pin state and counter
    // arrays are true control registers, so every element is reset explicitly.
    always_ff @(posedge clk_32k or posedge rst) begin
        if (rst) begin
            src_d1       <= '0;
            int_status   <= '0;
            int_pend_vld <= 1'b0;
            int_pend_id  <= '0;
            on_d1        <= '0;
            level_d1     <= '0;
            act_q        <= '0;
            retrig_q     <= '0;
            for (int k = 0; k < NOUT; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            src_d1       <= src_flag;
            int_status   <= status_nxt;
            int_pend_vld <= pend_vld_nxt;
            int_pend_id  <= pend_id_nxt;
            on_d1        <= on;
            level_d1     <= rg_out_level_en;
            act_q        <= act_d;
            retrig_q     <= retrig_d;
            for (int k = 0; k < NOUT; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign int_out = act_q ^ rg_out_low_en;

endmodule

// File: tb/tb_int_router.sv
// tb_int_router: directed sequence for int_router with a scoreboard of expected
// values pushed at stimulus time and popped at each comparison point.
module tb_int_router;

    logic        clk_32k = 1'b0;
    logic        rst;
    logic [15:0] src_flag;
    logic [15:0] rg_int_enable;
    logic [15:0] rg_int_clr;
    logic [31:0] rg_int_route;
    logic [1:0]  rg_out_low_en;
    logic [1:0]  rg_out_level_en;
    logic [1:0]  rg_out_repeat;
    logic [21:0] rg_out_width;
    logic [11:0] rg_cold_time;
    logic [15:0] int_status;
    logic        int_pend_vld;
    logic [4:0]  int_pend_id;
    logic [1:0]  int_out;

    int compared   = 0;
    int mismatched = 0;
    int n;

    string       tag_q[$];
    logic [31:0] val_q[$];

    logic watch_p0 = 1'b0;
    int   p0_high  = 0;

    int_router #(.NSRC(16), .NOUT(2), .WW(11), .CW(6)) dut (
        .clk_32k         (clk_32k),
        .rst             (rst),
        .src_flag        (src_flag),
        .rg_int_enable   (rg_int_enable),
        .rg_int_clr      (rg_int_clr),
        .rg_int_route    (rg_int_route),
        .rg_out_low_en   (rg_out_low_en),
        .rg_out_level_en (rg_out_level_en),
        .rg_out_repeat   (rg_out_repeat),
        .rg_out_width    (rg_out_width),
        .rg_cold_time    (rg_cold_time),
        .int_status      (int_status),
        .int_pend_vld    (int_pend_vld),
        .int_pend_id     (int_pend_id),
        .int_out         (int_out)
    );

    always #5 clk_32k = ~clk_32k;

    always @(negedge clk_32k) begin
        if (watch_p0 && int_out[0]) p0_high++;
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk_32k);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] observed);
        string       tag;
        logic [31:0] exp_v;
        compared++;
        if (val_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_underflow: observed 'h%0h, nothing expected", observed);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = val_q.pop_front();
            assert (observed === exp_v) else begin
                mismatched++;
                $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, exp_v);
            end
        end
    endtask

    // Length of the run of 'level' on a pin, starting at the current sample (bounded).
    task automatic run_len(input int pin, input logic level, output int len);
        len = 0;
        while (int_out[pin] === level && len < 500) begin
            len++;
            step(1);
        end
    endtask

    task automatic count_level(input int pin, input logic level, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            if (int_out[pin] === level) cnt++;
            step(1);
        end
    endtask

    initial begin
        rst             = 1'b1;
        src_flag        = '0;
        rg_int_enable   = '0;
        rg_int_clr      = '0;
        rg_int_route    = '0;
        rg_out_low_en   = 2'b11;
        rg_out_level_en = '0;
        rg_out_repeat   = '0;
        rg_out_width    = '0;
        rg_cold_time    = '0;
        step(2);
        rst = 1'b0;

        // Reset state
        expect_val("rst_out_inactive", 32'h3);
        check(int_out);
        expect_val("rst_status", 32'h0);
        check(int_status);
        expect_val("rst_pend_vld", 32'h0);
        check(int_pend_vld);
        expect_val("rst_pend_id", 32'h0);
        check(int_pend_id);
        rg_out_low_en = 2'b00;

        // Pulse basic: source 3 -> pin 0, width 4, cold 0, no repeat
        rg_int_enable      = 16'h0008;
        rg_int_route       = 32'h0000_0008;
        rg_out_width[10:0] = 11'd4;
        rg_cold_time[5:0]  = 6'd0;
        step(1);
        src_flag[3] = 1'b1;
        expect_val("p1_status_e0", 32'h0008);
        expect_val("p1_pend_vld_e0", 32'h1);
        expect_val("p1_pend_id_e0", 32'h3);
        expect_val("p1_out_e0", 32'h0);
        step(1);
        check(int_status);
        check(int_pend_vld);
        check(int_pend_id);
        check(int_out);
        expect_val("p1_out_e1", 32'h1);
        step(1);
        check(int_out);
        expect_val("p1_pulse_len", 32'd5);
        run_len(0, 1'b1, n);
        check(n);
        expect_val("p1_no_repulse", 32'd0);
        count_level(0, 1'b1, 80, n);
        check(n);

        // Repeat with cold 1: 5-cycle pulses separated by 64 inactive cycles
        rg_cold_time[5:0] = 6'd1;
        rg_out_repeat[0]  = 1'b1;
        rg_int_clr[3]     = 1'b1;
        src_flag[3]       = 1'b0;
        expect_val("p2_status_cleared", 32'h0);
        step(1);
        rg_int_clr[3] = 1'b0;
        check(int_status);
        src_flag[3] = 1'b1;
        step(2);
        expect_val("p2_first_pulse_len", 32'd5);
        run_len(0, 1'b1, n);
        check(n);
        expect_val("p2_cold_gap", 32'd64);
        run_len(0, 1'b0, n);
        check(n);
        expect_val("p2_pend_id", 32'h3);
        check(int_pend_id);
        expect_val("p2_second_pulse_len", 32'd5);
        run_len(0, 1'b1, n);
        check(n);
        rg_int_clr[3] = 1'b1;
        step(1);
        rg_int_clr[3] = 1'b0;
        expect_val("p2_clear_in_cold", 32'd0);
        count_level(0, 1'b1, 150, n);
        check(n);

        // Level mode, low-active on pin 1, sources 0 and 5
        rg_out_low_en[1]   = 1'b1;
        rg_out_level_en[1] = 1'b1;
        expect_val("p3_pin1_idle_high", 32'h2);
        step(1);
        check(int_out);
        rg_int_enable = rg_int_enable | 16'h0021;
        rg_int_route  = rg_int_route | 32'h0021_0000;
        src_flag[0]   = 1'b1;
        src_flag[5]   = 1'b1;
        expect_val("p3_status", 32'h0021);
        expect_val("p3_pend_id_0", 32'h0);
        expect_val("p3_pend_vld", 32'h1);
        step(1);
        check(int_status);
        check(int_pend_id);
        check(int_pend_vld);
        expect_val("p3_pin1_asserted", 32'h0);
        step(1);
        check(int_out);
        rg_int_clr[0] = 1'b1;
        expect_val("p3_pend_id_5", 32'h5);
        expect_val("p3_status_after_clr0", 32'h0020);
        step(1);
        rg_int_clr[0] = 1'b0;
        check(int_pend_id);
        check(int_status);
        expect_val("p3_pin1_held_low", 32'h0);
        step(3);
        check(int_out[1]);
        rg_int_clr[5] = 1'b1;
        expect_val("p3_pend_vld_end", 32'h0);
        expect_val("p3_pend_id_end", 32'h0);
        expect_val("p3_pin1_one_edge_after", 32'h0);
        step(1);
        rg_int_clr[5] = 1'b0;
        check(int_pend_vld);
        check(int_pend_id);
        check(int_out[1]);
        expect_val("p3_pin1_two_edges_after", 32'h1);
        step(1);
        check(int_out[1]);

        // Set/clear collision on source 2 (not enabled)
        src_flag[2]   = 1'b1;
        rg_int_clr[2] = 1'b1;
        expect_val("p4_collision_set_wins", 32'h0004);
        expect_val("p4_disabled_not_pending", 32'h0);
        step(1);
        rg_int_clr[2] = 1'b0;
        check(int_status);
        check(int_pend_vld);
        expect_val("p4_status_sticky", 32'h0004);
        step(1);
        check(int_status);
        rg_int_clr[2] = 1'b1;
        expect_val("p4_status_cleared", 32'h0);
        step(1);
        rg_int_clr[2] = 1'b0;
        check(int_status);

        // Retrig and routing isolation: pin 1 pulse mode, width 2, cold 0, no repeat
        rg_out_level_en[1]  = 1'b0;
        rg_out_low_en[1]    = 1'b0;
        rg_out_width[21:11] = 11'd2;
        rg_cold_time[11:6]  = 6'd0;
        src_flag[0]         = 1'b0;
        src_flag[5]         = 1'b0;
        rg_int_enable[7]    = 1'b1;
        rg_int_route[23]    = 1'b1;
        step(2);
        watch_p0    = 1'b1;
        src_flag[7] = 1'b1;
        expect_val("p5_status7", 32'h0080);
        expect_val("p5_pend_id7", 32'h7);
        step(1);
        check(int_status);
        check(int_pend_id);
        expect_val("p5_pin1_only", 32'h2);
        step(1);
        check(int_out);
        rg_int_clr[7] = 1'b1;
        expect_val("p5_status_clr_in_active", 32'h0);
        step(1);
        rg_int_clr[7] = 1'b0;
        check(int_status);
        expect_val("p5_pulse_not_shortened", 32'd3);
        run_len(1, 1'b1, n);
        check(n + 1);
        src_flag[5] = 1'b1;
        expect_val("p5_retrig_cold_gap", 32'd32);
        run_len(1, 1'b0, n);
        check(n);
        expect_val("p5_retrig_pulse_len", 32'd3);
        run_len(1, 1'b1, n);
        check(n);
        expect_val("p5_no_pulse_after_retrig", 32'd0);
        count_level(1, 1'b1, 80, n);
        check(n);
        watch_p0 = 1'b0;
        expect_val("p5_pin0_isolated", 32'd0);
        check(p0_high);

        // Disable source 7: pending drops, status stays
        rg_int_clr[5] = 1'b1;
        src_flag[7]   = 1'b0;
        step(1);
        rg_int_clr[5] = 1'b0;
        src_flag[7]   = 1'b1;
        expect_val("p5_status7_again", 32'h0080);
        expect_val("p5_pend_vld_enabled", 32'h1);
        step(1);
        check(int_status);
        check(int_pend_vld);
        rg_int_enable[7] = 1'b0;
        expect_val("p5_pend_vld_disabled", 32'h0);
        expect_val("p5_status_kept", 32'h0080);
        step(1);
        check(int_pend_vld);
        check(int_status);
        step(60);

        // Reset mid-ACTIVE on low-active pin 0
        rg_out_low_en[0] = 1'b1;
        src_flag[3]      = 1'b0;
        step(1);
        src_flag[3] = 1'b1;
        step(2);
        expect_val("p6_pin0_active_low", 32'h0);
        check(int_out[0]);
        step(1);
        #2;
        rst      = 1'b1;
        src_flag = '0;
        expect_val("p6_out_inactive_async", 32'h1);
        expect_val("p6_status_async", 32'h0);
        #1;
        check(int_out);
        check(int_status);
        step(2);
        rst = 1'b0;
        expect_val("p6_no_pulse_after_reset", 32'd0);
        count_level(0, 1'b0, 40, n);
        check(n);
        expect_val("p6_status_after_reset", 32'h0);
        check(int_status);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
